// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin multi-warp issue control for one shared fetch/decode/execute pipeline.
// Define WARP_SCHED_PERF_EN to add saturating perf_issued / perf_bubbles counters.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | waiting for the fetcher to present active_warp's instruction
// DECODE  | decoder settling
// REQUEST | memory op issued and warp parked, or ALU op passed on
// WAIT    | reserved, never entered
// EXECUTE | ALU op executing
// UPDATE  | PC/register update; RET retires the warp unless on the resume path
// DONE    | all warps finished, held until reset
// SELECT  | round-robin pick of the next READY/RESUME warp
module warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int WID_BITS  = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WID_BITS:0]    warp_count,
    input  logic                 request_ready,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic                 decoded_ret,
    input  logic [NUM_WARPS-1:0] mem_done,
    output logic [3:0]           core_state,
    output logic [WID_BITS-1:0]  active_warp,
    output logic                 mem_issue,
    output logic [NUM_WARPS-1:0] warp_finished,
    output logic                 done
`ifdef WARP_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_issued,
    output logic [15:0]          perf_bubbles
`endif
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_REQUEST = 4'd3,
        S_WAIT    = 4'd4,
        S_EXECUTE = 4'd5,
        S_UPDATE  = 4'd6,
        S_DONE    = 4'd7,
        S_SELECT  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        W_INACTIVE = 2'd0,
        W_READY    = 2'd1,
        W_STALLED  = 2'd2,
        W_RESUME   = 2'd3
    } wstat_t;

    state_t                 r_state;
    state_t                 w_next_state;
    wstat_t                 r_status [NUM_WARPS];
    logic [NUM_WARPS-1:0]   r_finished;
    logic [WID_BITS-1:0]    r_active;
    logic [WID_BITS-1:0]    r_rr_ptr;
    logic                   r_resume_path;

    logic                   w_mem_op;
    logic                   w_launch;
    logic                   w_mem_issue;
    logic [WID_BITS:0]      w_count_clamped;
    logic                   w_hit;
    logic                   w_hit_resume;
    logic [WID_BITS-1:0]    w_hit_idx;
    int                     w_scan_idx;

    assign w_mem_op        = decoded_mem_read_enable | decoded_mem_write_enable;
    assign w_launch        = (r_state == S_IDLE) && start;
    assign w_count_clamped = (warp_count > (WID_BITS+1)'(NUM_WARPS)) ?
                             (WID_BITS+1)'(NUM_WARPS) : warp_count;

    // Scan starts one past the last issued warp; first eligible index wins.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_resume = 1'b0;
        w_hit_idx    = '0;
        w_scan_idx   = 0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_scan_idx = (int'(r_rr_ptr) + i) % NUM_WARPS;
            if (!w_hit && (r_status[w_scan_idx] == W_READY || r_status[w_scan_idx] == W_RESUME)) begin
                w_hit        = 1'b1;
                w_hit_resume = (r_status[w_scan_idx] == W_RESUME);
                w_hit_idx    = WID_BITS'(w_scan_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_issue  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (w_count_clamped == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (w_hit) begin
                    w_next_state = w_hit_resume ? S_UPDATE : S_FETCH;
                end else if (&r_finished) begin
                    w_next_state = S_DONE;
                end
            end
            S_FETCH: begin
                if (request_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE:  w_next_state = S_REQUEST;
            S_REQUEST: begin
                if (w_mem_op) begin
                    w_mem_issue  = 1'b1;
                    w_next_state = S_SELECT;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: w_next_state = S_UPDATE;
            S_UPDATE:  w_next_state = S_SELECT;
            S_DONE:    w_next_state = S_DONE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Parking in REQUEST takes priority over a same-cycle mem_done for that warp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_status[w] <= W_INACTIVE;
            end
            r_finished <= '0;
        end else if (w_launch) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if ((WID_BITS+1)'(w) < w_count_clamped) begin
                    r_status[w]   <= W_READY;
                    r_finished[w] <= 1'b0;
                end else begin
                    r_status[w]   <= W_INACTIVE;
                    r_finished[w] <= 1'b1;
                end
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (r_state == S_REQUEST && w_mem_op && r_active == WID_BITS'(w)) begin
                    r_status[w] <= W_STALLED;
                end else if (r_state == S_UPDATE && r_active == WID_BITS'(w)) begin
                    if (decoded_ret && !r_resume_path) begin
                        r_status[w]   <= W_INACTIVE;
                        r_finished[w] <= 1'b1;
                    end else begin
                        r_status[w] <= W_READY;
                    end
                end else if (r_status[w] == W_STALLED && mem_done[w]) begin
                    r_status[w] <= W_RESUME;
                end
            end
        end
    end

    // Launch presets the pointer to the last warp so the first scan begins at warp 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active      <= '0;
            r_rr_ptr      <= '0;
            r_resume_path <= 1'b0;
        end else if (w_launch) begin
            r_rr_ptr      <= WID_BITS'(NUM_WARPS - 1);
            r_resume_path <= 1'b0;
        end else if (r_state == S_SELECT && w_hit) begin
            r_active      <= w_hit_idx;
            r_rr_ptr      <= w_hit_idx;
            r_resume_path <= w_hit_resume;
        end
    end

`ifdef WARP_SCHED_PERF_EN
    logic [15:0] r_perf_issued;
    logic [15:0] r_perf_bubbles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_issued  <= '0;
            r_perf_bubbles <= '0;
        end else if (w_launch) begin
            r_perf_issued  <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (r_state == S_UPDATE && !r_resume_path && r_perf_issued != 16'hFFFF) begin
                r_perf_issued <= r_perf_issued + 16'd1;
            end
            if (r_state == S_SELECT && !w_hit && r_perf_bubbles != 16'hFFFF) begin
                r_perf_bubbles <= r_perf_bubbles + 16'd1;
            end
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_bubbles = r_perf_bubbles;
`endif

    assign core_state    = r_state;
    assign active_warp   = r_active;
    assign mem_issue     = w_mem_issue;
    assign warp_finished = r_finished;
    assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed testbench for warp_scheduler (NUM_WARPS=4): reset, launch, round-robin issue, parking and resume.
module tb_warp_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] warp_count;
    logic       request_ready;
    logic       decoded_mem_read_enable;
    logic       decoded_mem_write_enable;
    logic       decoded_ret;
    logic [3:0] mem_done;
    logic [3:0] core_state;
    logic [1:0] active_warp;
    logic       mem_issue;
    logic [3:0] warp_finished;
    logic       done;
`ifdef WARP_SCHED_PERF_EN
    logic [15:0] perf_issued;
    logic [15:0] perf_bubbles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    warp_scheduler dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .warp_count               (warp_count),
        .request_ready            (request_ready),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_ret              (decoded_ret),
        .mem_done                 (mem_done),
        .core_state               (core_state),
        .active_warp              (active_warp),
        .mem_issue                (mem_issue),
        .warp_finished            (warp_finished),
        .done                     (done)
`ifdef WARP_SCHED_PERF_EN
        ,
        .perf_issued              (perf_issued),
        .perf_bubbles             (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset                    = 1'b1;
        start                    = 1'b0;
        warp_count               = 3'd0;
        request_ready            = 1'b0;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_ret              = 1'b0;
        mem_done                 = 4'd0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;
        int pulses;

        // Reset values
        do_reset();
        chk("rst_state", core_state, 32'd0);
        chk("rst_active", active_warp, 32'd0);
        chk("rst_mem_issue", mem_issue, 32'd0);
        chk("rst_finished", warp_finished, 32'd0);
        chk("rst_done", done, 32'd0);

        // Reset asserted while in FETCH
        warp_count = 3'd2;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_select", core_state, 32'd8);
        cyc();
        chk("t1_fetch", core_state, 32'd1);
        reset = 1'b1;
        #1;
        chk("t1_async_state", core_state, 32'd0);
        chk("t1_async_finished", warp_finished, 32'd0);
        cyc();
        reset = 1'b0;
        chk("t1_state", core_state, 32'd0);
        chk("t1_done", done, 32'd0);
        chk("t1_active", active_warp, 32'd0);
        chk("t1_finished", warp_finished, 32'd0);

        // warp_count=0 goes straight to DONE with every warp flagged finished
        warp_count = 3'd0;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2_state", core_state, 32'd7);
        chk("t2_done", done, 32'd1);
        chk("t2_finished", warp_finished, 32'hF);
        cyc();
        chk("t2_done_held", done, 32'd1);

        // warp_count above NUM_WARPS clamps to 4: nothing pre-finished, warp 0 first
        do_reset();
        warp_count    = 3'd7;
        request_ready = 1'b1;
        start         = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2b_finished", warp_finished, 32'h0);
        cyc();
        chk("t2b_fetch", core_state, 32'd1);
        chk("t2b_active", active_warp, 32'd0);

        // Two ALU-only warps, each retiring on its third instruction
        do_reset();
        warp_count    = 3'd2;
        request_ready = 1'b1;
        start         = 1'b1;
        cyc();
        start = 1'b0;
        chk("t3_select", core_state, 32'd8);
        cnt    = 0;
        k      = 0;
        pulses = 0;
        while (!done && cnt < 100) begin
            cyc();
            cnt++;
            if (mem_issue) pulses++;
            if (core_state == 4'd1) begin
                if (k < 6) chk($sformatf("t3_issue%0d", k), active_warp, 32'(k % 2));
                k++;
                decoded_ret = (k >= 5);
            end
        end
        decoded_ret = 1'b0;
        chk("t3_issue_count", k, 32'd6);
        chk("t3_cycles", cnt, 32'd37);
        chk("t3_done", done, 32'd1);
        chk("t3_finished", warp_finished, 32'hF);
        chk("t3_no_mem_issue", pulses, 32'd0);

        // Warp 0 LDR parks; warp 1 runs; mem_done[0] resumes warp 0 straight into UPDATE
        do_reset();
        warp_count    = 3'd2;
        request_ready = 1'b1;
        start         = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t4_fetch0", core_state, 32'd1);
        chk("t4_active0", active_warp, 32'd0);
        decoded_mem_read_enable = 1'b1;
        cyc();
        cyc();
        chk("t4_request", core_state, 32'd3);
        chk("t4_mem_issue", mem_issue, 32'd1);
        cyc();
        decoded_mem_read_enable = 1'b0;
        chk("t4_switch_select", core_state, 32'd8);
        chk("t4_issue_pulse_end", mem_issue, 32'd0);
        cyc();
        chk("t4_fetch1", core_state, 32'd1);
        chk("t4_active1", active_warp, 32'd1);
        cyc();
        cyc();
        chk("t4_alu_no_issue", mem_issue, 32'd0);
        cyc();
        mem_done = 4'b0001;
        cyc();
        mem_done = 4'b0000;
        chk("t4_update1", core_state, 32'd6);
        cyc();
        chk("t4_select", core_state, 32'd8);
        cyc();
        chk("t4_resume_update", core_state, 32'd6);
        chk("t4_resume_active", active_warp, 32'd0);
        decoded_ret = 1'b1;
        cyc();
        decoded_ret = 1'b0;
        chk("t4_ret_ignored", warp_finished, 32'hC);
        cyc();
        chk("t4_next_fetch", core_state, 32'd1);
        chk("t4_next_active", active_warp, 32'd1);

        // Both warps parked: bubble in SELECT, simultaneous completion, round-robin resume order
        do_reset();
        warp_count    = 3'd2;
        request_ready = 1'b1;
        start         = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        cyc();
        chk("t5_sel_a", core_state, 32'd8);
        cyc();
        chk("t5_fetch_w1", active_warp, 32'd1);
        decoded_mem_read_enable = 1'b1;
        cyc();
        cyc();
        chk("t5_issue_w1", mem_issue, 32'd1);
        cyc();
        cyc();
        chk("t5_fetch_w0", core_state, 32'd1);
        chk("t5_active_w0", active_warp, 32'd0);
        cyc();
        cyc();
        chk("t5_issue_w0", mem_issue, 32'd1);
        cyc();
        decoded_mem_read_enable = 1'b0;
        chk("t5_stall0", core_state, 32'd8);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk($sformatf("t5_stall%0d", i), core_state, 32'd8);
        end
        mem_done = 4'b0011;
        cyc();
        mem_done = 4'b0000;
        chk("t5_stall4", core_state, 32'd8);
        cyc();
        chk("t5_resume1_state", core_state, 32'd6);
        chk("t5_resume1_active", active_warp, 32'd1);
        cyc();
        chk("t5_sel_b", core_state, 32'd8);
        cyc();
        chk("t5_resume0_state", core_state, 32'd6);
        chk("t5_resume0_active", active_warp, 32'd0);
        cyc();
`ifdef WARP_SCHED_PERF_EN
        chk("t6_bubbles", perf_bubbles, 32'd4);
        chk("t6_issued", perf_issued, 32'd1);
`endif
        cyc();
        chk("t5_after_fetch", core_state, 32'd1);
        chk("t5_after_active", active_warp, 32'd1);
        chk("t5_finished", warp_finished, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
